// File: rtl/bpu_pkg.sv
// Shared types for the branch predictor: 2-bit counter states, lookup entry view, counter step.
// Entry fields are sized to BPU_XLEN, so instances may use XLEN up to 32.
package bpu_pkg;

  localparam int BPU_XLEN = 32;

  typedef enum logic [1:0] {
    CNT_SNT = 2'd0,
    CNT_WNT = 2'd1,
    CNT_WT  = 2'd2,
    CNT_ST  = 2'd3
  } cnt_t;

  // Tags are zero-extended into the full-width field.
  typedef struct packed {
    logic                valid;
    logic [BPU_XLEN-1:0] tag;
    logic [BPU_XLEN-1:0] target;
    cnt_t                cnt;
  } bpu_entry_t;

  function automatic cnt_t next_cnt(input cnt_t cnt, input logic taken);
    cnt_t nxt;
    case (cnt)
      CNT_SNT: nxt = taken ? CNT_WNT : CNT_SNT;
      CNT_WNT: nxt = taken ? CNT_WT  : CNT_SNT;
      CNT_WT:  nxt = taken ? CNT_ST  : CNT_WNT;
      CNT_ST:  nxt = taken ? CNT_ST  : CNT_WT;
      default: nxt = CNT_WNT;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/branch_predict_unit_if.sv
// IF lookup / ID update bundle between the pipeline (master) and the predictor (slave).
// Plain single-cycle signals; the predictor never stalls the pipeline.
interface branch_predict_unit_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] if_pc_i;
  logic            pred_hit_o;
  logic            pred_taken_o;
  logic [XLEN-1:0] pred_pc_o;

  logic            upd_valid_i;
  logic [XLEN-1:0] upd_pc_i;
  logic            upd_taken_i;
  logic [XLEN-1:0] upd_target_i;
  logic            upd_pred_taken_i;
  logic [XLEN-1:0] upd_pred_pc_i;
  logic            flush_tbl_i;

  logic            mispredict_o;
  logic [XLEN-1:0] redirect_pc_o;

  modport master (
    output if_pc_i, upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i,
           upd_pred_taken_i, upd_pred_pc_i, flush_tbl_i,
    input  pred_hit_o, pred_taken_o, pred_pc_o, mispredict_o, redirect_pc_o
  );

  modport slave (
    input  if_pc_i, upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i,
           upd_pred_taken_i, upd_pred_pc_i, flush_tbl_i,
    output pred_hit_o, pred_taken_o, pred_pc_o, mispredict_o, redirect_pc_o
  );
endinterface

// File: rtl/bpu_sat_counter.sv
// Per-entry 2-bit saturating direction counter; load_en forces weakly-taken on allocation.
// Updates at the clock edge, no backpressure.
module bpu_sat_counter
  import bpu_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic upd_en,
  input  logic load_en,
  input  logic taken,
  output cnt_t cnt
);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt <= CNT_WNT;
    end else if (load_en) begin
      cnt <= CNT_WT;
    end else if (upd_en) begin
      cnt <= next_cnt(cnt, taken);
    end
  end

endmodule

// File: rtl/branch_predict_unit.sv
// BTB + 2-bit BHT: zero-latency combinational IF lookup, ID-side training and mispredict redirect.
// Never stalls; optional BPU_STATS_EN adds saturating branch/mispredict counters.
module branch_predict_unit
  import bpu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  branch_predict_unit_if.slave bus
`ifdef BPU_STATS_EN
  ,
  output logic [31:0] stat_branches_o,
  output logic [31:0] stat_mispred_o
`endif
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [XLEN-1:0]  target_q [ENTRIES];
  cnt_t             cnt_w    [ENTRIES];

  logic [IDX_W-1:0] lk_idx;
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] lk_tag;
  logic [TAG_W-1:0] up_tag;
  bpu_entry_t       lk_e;
  logic             lk_hit;
  logic             up_hit;
  logic             upd_we;

  assign lk_idx = bus.if_pc_i[IDX_W+1:2];
  assign lk_tag = bus.if_pc_i[XLEN-1:IDX_W+2];
  assign up_idx = bus.upd_pc_i[IDX_W+1:2];
  assign up_tag = bus.upd_pc_i[XLEN-1:IDX_W+2];

  // Lookup reads pre-edge contents; a same-cycle update to this index is not bypassed.
  always_comb begin
    lk_e        = '0;
    lk_e.valid  = valid_q[lk_idx];
    lk_e.tag    = BPU_XLEN'(tag_q[lk_idx]);
    lk_e.target = BPU_XLEN'(target_q[lk_idx]);
    lk_e.cnt    = cnt_w[lk_idx];
  end

  assign lk_hit           = lk_e.valid && (lk_e.tag == BPU_XLEN'(lk_tag));
  assign bus.pred_hit_o   = lk_hit;
  assign bus.pred_taken_o = lk_hit && (lk_e.cnt >= CNT_WT);
  assign bus.pred_pc_o    = bus.pred_taken_o ? XLEN'(lk_e.target) : bus.if_pc_i + XLEN'(4);

  assign bus.mispredict_o = bus.upd_valid_i &
                            ((bus.upd_taken_i != bus.upd_pred_taken_i) |
                             (bus.upd_taken_i & (bus.upd_pred_pc_i != bus.upd_target_i)));

  assign bus.redirect_pc_o = !bus.upd_valid_i ? '0 :
                             bus.upd_taken_i  ? bus.upd_target_i :
                                                bus.upd_pc_i + XLEN'(4);

  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
  // Flush wins over a coincident update.
  assign upd_we = bus.upd_valid_i && !bus.flush_tbl_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
      end
    end else if (bus.flush_tbl_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
      end
    end else if (upd_we && bus.upd_taken_i) begin
      // Taken: refresh target on hit, allocate (overwrite) on miss.
      if (!up_hit) begin
        valid_q[up_idx] <= 1'b1;
        tag_q[up_idx]   <= up_tag;
      end
      target_q[up_idx] <= bus.upd_target_i;
    end
  end

  for (genvar g = 0; g < ENTRIES; g++) begin : g_cnt
    logic sel;
    assign sel = upd_we && (up_idx == IDX_W'(g));

    bpu_sat_counter u_cnt (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .upd_en  (sel && up_hit),
      .load_en (sel && !up_hit && bus.upd_taken_i),
      .taken   (bus.upd_taken_i),
      .cnt     (cnt_w[g])
    );
  end

`ifdef BPU_STATS_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stat_branches_o <= '0;
      stat_mispred_o  <= '0;
    end else if (bus.flush_tbl_i) begin
      stat_branches_o <= '0;
      stat_mispred_o  <= '0;
    end else begin
      if (bus.upd_valid_i && (stat_branches_o != '1)) stat_branches_o <= stat_branches_o + 32'd1;
      if (bus.mispredict_o && (stat_mispred_o != '1)) stat_mispred_o  <= stat_mispred_o + 32'd1;
    end
  end
`endif

endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
- Parametrised branch target buffer (BTB) with a 2-bit saturating-counter branch history table (BHT).
- Successor to the fixed "predict not-taken, resolve beq in ID, flush IF" scheme of the current 5-stage pipeline.
- IF side: looks up the current PC in the same cycle as instruction memory and supplies the predicted next PC.
- ID side: takes the branch outcome resolved in ID, trains the table, and raises a mispredict redirect that drives PC select and the IF/ID flush.

Parameters:
- XLEN, 32: address/data width.
- ENTRIES, 16: BTB/BHT entry count; power of two, 2..256.
- IDX_W, log2(ENTRIES): index width (localparam).
- TAG_W, XLEN-IDX_W-2: tag width (localparam).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-low
- if_pc_i  in  XLEN  PC currently being fetched
- pred_hit_o  out  1  valid tag match for if_pc_i
- pred_taken_o  out  1  hit and counter >= 2
- pred_pc_o  out  XLEN  predicted next PC: stored target if pred_taken_o, else if_pc_i+4
- upd_valid_i  in  1  ID holds a conditional branch this cycle (not asserted while ID is stalled or flushed)
- upd_pc_i  in  XLEN  PC of the branch in ID
- upd_taken_i  in  1  resolved outcome
- upd_target_i  in  XLEN  resolved taken target (PC + imm<<1)
- upd_pred_taken_i  in  1  prediction carried through IF/ID
- upd_pred_pc_i  in  XLEN  predicted next PC carried through IF/ID
- flush_tbl_i  in  1  invalidate all entries
- mispredict_o  out  1  redirect required; drives PC select and IF/ID flush
- redirect_pc_o  out  XLEN  correct next PC: upd_target_i if taken, else upd_pc_i+4

Behaviour:
- Reset is asynchronous, active-low. All valid bits clear, all counters = 2'b01, tags/targets = 0.
- Outputs in reset: pred_hit_o = 0, pred_taken_o = 0, pred_pc_o = if_pc_i+4.
- mispredict_o and redirect_pc_o are combinational on the upd_* inputs and are 0 whenever upd_valid_i = 0.
- Index = pc[IDX_W+1:2]; tag = pc[XLEN-1:IDX_W+2]. pc[1:0] is ignored.
- Lookup is fully combinational: zero-cycle latency, no registers on the IF path.
- mispredict_o = upd_valid_i & ((upd_taken_i != upd_pred_taken_i) | (upd_taken_i & upd_pred_pc_i != upd_target_i)).
- All table writes happen at the rising edge when upd_valid_i = 1.
- Per-entry counter is a 4-state FSM: SNT(0) <-> WNT(1) <-> WT(2) <-> ST(3). Taken increments, not-taken decrements, saturating at both ends.
- Hit, taken: counter increments and target <= upd_target_i.
- Hit, not taken: counter decrements; target unchanged.
- Miss, taken: allocate (overwrite) the entry: valid = 1, tag written, target written, counter = WT.
- Miss, not taken: no write.
- Same-cycle lookup and update to the same index: lookup returns the pre-edge contents; no bypass.
- flush_tbl_i clears all valid bits at the next edge and takes priority over a simultaneous update (the update is dropped). Counters and targets are kept.
- Arithmetic: +4 is modulo 2^XLEN. A PC of 32'hFFFF_FFFC yields 32'h0000_0000.

Optional Feature:
- BPU_STATS_EN defined: adds two saturating 32-bit counters, stat_branches_o and stat_mispred_o.
  - They count upd_valid_i and mispredict_o cycles respectively.
  - Both reset to 0, saturate at 32'hFFFF_FFFF, and are cleared by flush_tbl_i.
- BPU_STATS_EN undefined: the ports and counters are absent, and prediction behaviour is identical.

Decomposition:
- Shared package bpu_pkg holds:
  - counter-state constants CNT_SNT, CNT_WNT, CNT_WT, CNT_ST;
  - the entry struct {valid, tag, target, cnt};
  - the function next_cnt(cnt, taken).
- One natural sub-module, bpu_sat_counter: a 2-bit saturating counter with update enable, instantiated per entry (generate loop).
- Tag/target storage stays as a register array in the top module.

Test Plan:
- Reset, if_pc_i = 0x40 -> pred_hit_o = 0, pred_taken_o = 0, pred_pc_o = 0x44.
- Update with pc 0x40, taken, target 0x80, pred_taken 0 -> mispredict_o = 1, redirect_pc_o = 0x80. Next cycle, lookup 0x40 -> hit, taken, pred_pc_o = 0x80.
- Two not-taken updates at 0x40 (counter WT -> WNT -> SNT) -> pred_taken_o = 0, pred_pc_o = 0x44. Third not-taken update keeps SNT. Two taken updates (SNT -> WNT -> WT) -> predicts taken again.
- ENTRIES = 16: taken branch at 0x40 then taken branch at 0x80 (same index, different tag) -> 0x40 lookup misses, 0x80 hits.
- Predicted taken to 0x80, resolved taken to 0x90 -> mispredict_o = 1, redirect_pc_o = 0x90, stored target becomes 0x90.
- flush_tbl_i together with upd_valid_i -> all lookups miss next cycle and the update is not applied. With BPU_STATS_EN, the stat counters read 0.
